// File: rtl/uart_rx_fifo.sv
// UART receive FIFO.
// Bytes are captured on the rising edge of rx_done. They are stored in a
// DEPTH-entry circular buffer and popped on the APB read path.
// Sticky overrun and frame_err flags, together with the level threshold,
// drive the rx_irq output.
//
// Read handshake: rd_en is a request with no backpressure. Each cycle that
// rd_en is high and the FIFO is not empty pops exactly one byte. rd_data is
// updated on the following edge, and rd_valid is high for exactly that one
// cycle. A request made while the FIFO is empty is ignored: rd_data holds its
// value and rd_valid stays low.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       rst,
  input  logic                       rx_done,
  input  logic                       rx_err,
  input  logic [7:0]                 rx_data,
  input  logic                       rd_en,
  input  logic                       clr_flags,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overrun,
  output logic                       frame_err,
  output logic                       rx_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          done_q;

  logic wr_ev;
  logic pop;
  logic push_ok;
  logic set_ovr;
  logic set_ferr;

  // Decode one write event per rx_done rising edge. A pop alongside a full
  // FIFO frees a slot in the same cycle, so the write is accepted and no
  // overrun is flagged.
  always_comb begin
    wr_ev    = rx_done & ~done_q;
    pop      = rd_en & ~empty;
    push_ok  = wr_ev & ~rx_err & (~full | pop);
    set_ovr  = wr_ev & ~rx_err & full & ~pop;
    set_ferr = wr_ev & rx_err;
  end

  // Status is derived from level rather than from pointer comparison. The
  // interrupt is a combinational function of level and the registered flags.
  always_comb begin
    empty  = (level == '0);
    full   = (level == LW'(DEPTH));
    rx_irq = (level >= LW'(THRESH)) | overrun | frame_err;
  end

  // Storage array: written only on an accepted push. It has no reset;
  // stale contents are unreachable once level is cleared.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // rx_done edge detector. It keeps tracking during rst so that a done held
  // across a flush does not produce a second push.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= rx_done;
    end
  end

  // Pointers, level and read port. rst flushes the FIFO and overrides any
  // push or pop in the same cycle; rd_data keeps its last value.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push_ok) begin
        level <= level - LW'(1);
      end
    end
  end

  // Sticky error flags. A set event in the same cycle as clr_flags takes
  // priority, so the flag stays 1.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (set_ovr) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end
      if (set_ferr) begin
        frame_err <= 1'b1;
      end else if (clr_flags) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo (DEPTH=8, THRESH=4).
// Each byte that should come out of the FIFO is queued when it is pushed.
// A monitor compares every rd_valid pulse against the head of that queue.
module tb_uart_rx_fifo;

  logic       clk;
  logic       arst_n;
  logic       rst;
  logic       rx_done;
  logic       rx_err;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       clr_flags;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [3:0] level;
  logic       overrun;
  logic       frame_err;
  logic       rx_irq;

  logic [7:0] exp_q[$];
  int checks;
  int failures;

  uart_rx_fifo #(.DEPTH(8), .THRESH(4)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rx_data   (rx_data),
    .rd_en     (rd_en),
    .clr_flags (clr_flags),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overrun   (overrun),
    .frame_err (frame_err),
    .rx_irq    (rx_irq)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, run did not reach summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (arst_n === 1'b1 && rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_data: got %0h with no byte expected", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL pop_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic err);
    rx_done = 1'b1;
    rx_data = d;
    rx_err  = err;
    tick();
    rx_done = 1'b0;
    rx_err  = 1'b0;
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pop_idle();
    pop();
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"},     32'(level),     32'd0);
    check({tag, "_empty"},     32'(empty),     32'd1);
    check({tag, "_full"},      32'(full),      32'd0);
    check({tag, "_rd_data"},   32'(rd_data),   32'h00);
    check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_rx_irq"},    32'(rx_irq),    32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    arst_n    = 1'b0;
    rst       = 1'b0;
    rx_done   = 1'b0;
    rx_err    = 1'b0;
    rx_data   = 8'h00;
    rd_en     = 1'b0;
    clr_flags = 1'b0;

    // Reset state
    #23;
    check_reset_values("reset");
    arst_n = 1'b1;
    tick();

    // Single byte round trip with one-cycle read latency
    exp_q.push_back(8'hD3);
    push(8'hD3, 1'b0);
    check("d3_level", 32'(level), 32'd1);
    pop();
    check("d3_rd_data",  32'(rd_data),  32'hD3);
    check("d3_rd_valid", 32'(rd_valid), 32'd1);
    check("d3_empty",    32'(empty),    32'd1);
    check("d3_level0",   32'(level),    32'd0);
    tick();

    // Fill to DEPTH, then overrun with FF, which must never be popped
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i), 1'b0);
    end
    check("fill_full",  32'(full),  32'd1);
    check("fill_level", 32'(level), 32'd8);
    push(8'hFF, 1'b0);
    check("ovr_flag",  32'(overrun), 32'd1);
    check("ovr_level", 32'(level),   32'd8);
    check("ovr_irq",   32'(rx_irq),  32'd1);
    for (int i = 0; i < 8; i++) pop_idle();
    check("drain_empty", 32'(empty), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_irq",     32'(rx_irq),  32'd0);

    // rx_done held 5 cycles pushes once; an error frame is discarded
    exp_q.push_back(8'hA5);
    rx_done = 1'b1;
    rx_data = 8'hA5;
    repeat (5) tick();
    rx_done = 1'b0;
    tick();
    check("hold_level", 32'(level), 32'd1);
    push(8'h5A, 1'b1);
    check("ferr_level", 32'(level),     32'd1);
    check("ferr_flag",  32'(frame_err), 32'd1);
    check("ferr_irq",   32'(rx_irq),    32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("ferr_clr", 32'(frame_err), 32'd0);
    pop_idle();

    // Simultaneous push and pop at full, then 20 pairs across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      push(8'h10 + 8'(i), 1'b0);
    end
    for (int i = 0; i < 21; i++) begin
      logic [7:0] d;
      d = (i == 0) ? 8'h42 : 8'h60 + 8'(i);
      exp_q.push_back(d);
      rx_done = 1'b1;
      rx_data = d;
      rd_en   = 1'b1;
      tick();
      rx_done = 1'b0;
      rd_en   = 1'b0;
      tick();
      if (i == 0) begin
        check("pp_overrun", 32'(overrun), 32'd0);
        check("pp_level",   32'(level),   32'd8);
      end
    end
    check("wrap_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) pop_idle();
    check("wrap_empty", 32'(empty), 32'd1);

    // Threshold crossing and a pop request while empty
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      push(8'h20 + 8'(i), 1'b0);
    end
    check("thr3_irq", 32'(rx_irq), 32'd0);
    exp_q.push_back(8'h23);
    push(8'h23, 1'b0);
    check("thr4_irq", 32'(rx_irq), 32'd1);
    for (int i = 0; i < 4; i++) pop_idle();
    pop();
    check("epop_valid", 32'(rd_valid), 32'd0);
    check("epop_data",  32'(rd_data),  32'h23);
    check("epop_level", 32'(level),    32'd0);
    tick();

    // Asynchronous reset in the middle of the stream
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 1'b0);
    check("pre_arst_level", 32'(level), 32'd5);
    #2;
    arst_n = 1'b0;
    #1;
    check_reset_values("arst");
    tick();
    arst_n = 1'b1;
    tick();

    // Synchronous flush overrides a simultaneous push and pop
    push(8'h55, 1'b0);
    check("pre_rst_level", 32'(level), 32'd1);
    rst     = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'h77;
    rd_en   = 1'b1;
    tick();
    rst     = 1'b0;
    rx_done = 1'b0;
    rd_en   = 1'b0;
    check("rst_level",    32'(level),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'h00);
    tick();
    exp_q.push_back(8'h66);
    push(8'h66, 1'b0);
    check("post_rst_level", 32'(level), 32'd1);
    pop_idle();
    tick();

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter THRESH, default 4, level at or above which rx_irq asserts; 1..DEPTH.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 rst  input  1  synchronous flush, active-high.
REQ-006 rx_done  input  1  frame-complete strobe from the UART receiver.
REQ-007 rx_err  input  1  framing error for the current frame, valid with rx_done.
REQ-008 rx_data  input  8  received byte, valid with rx_done.
REQ-009 rd_en  input  1  pop request from the APB read path, one pop per cycle high.
REQ-010 clr_flags  input  1  clears the sticky overrun and frame_err flags.
REQ-011 rd_data  output  8  popped byte, registered.
REQ-012 rd_valid  output  1  one-cycle pulse, rd_data updated this cycle.
REQ-013 empty  output  1  level == 0.
REQ-014 full  output  1  level == DEPTH.
REQ-015 level  output  clog2(DEPTH)+1  number of stored bytes.
REQ-016 overrun  output  1  sticky, a byte was dropped because the FIFO was full.
REQ-017 frame_err  output  1  sticky, a frame arrived with rx_err set.
REQ-018 rx_irq  output  1  level >= THRESH, or overrun, or frame_err.

Function
REQ-019 Write event SHALL be the rising edge of rx_done (registered previous value), so a done held for several cycles pushes once.
REQ-020 On a write event with rx_err=0 and not full, rx_data SHALL be stored at wr_ptr; wr_ptr and level increment next edge.
REQ-021 On a write event with rx_err=1, the byte SHALL be discarded and frame_err set; level unchanged.
REQ-022 On a write event when full and no pop the same cycle, the byte SHALL be dropped and overrun set; stored contents untouched.
REQ-023 rd_en when not empty SHALL load rd_data from rd_ptr and pulse rd_valid on the next edge (1-cycle latency); rd_ptr increments, level decrements.
REQ-024 rd_en when empty SHALL be ignored: rd_data holds, rd_valid stays 0, level stays 0.
REQ-025 Simultaneous valid write and pop SHALL both proceed, level unchanged; this includes full (no overrun) and empty (pop ignored, write succeeds, level 0->1).
REQ-026 Pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-027 Full/empty SHALL be derived from level, not pointer equality alone.
REQ-028 clr_flags SHALL clear overrun and frame_err next edge; a set event in the same cycle SHALL win (flag stays 1).
REQ-029 rx_irq SHALL be combinational from level and the registered flags.
REQ-030 rst SHALL, on the next edge, zero pointers, level and flags, force rd_valid=0 and hold rd_data; it overrides simultaneous writes and pops.

Reset
REQ-031 With arst_n low: pointers=0, level=0, empty=1, full=0, rd_data=8'h00, rd_valid=0, overrun=0, frame_err=0, rx_irq=0, rx_done edge register=0.
REQ-032 Reset mid-operation SHALL discard all stored bytes; storage array contents need no reset.
REQ-033 Release SHALL be taken synchronously to clk; first write accepted on the first edge after release.

Verification
REQ-034 Push 8'hD3 (rx_done pulse, rx_err=0), pop -> one cycle later rd_data=8'hD3, rd_valid=1, empty=1, level=0.
REQ-035 Push 8'h00..8'h07 (DEPTH=8), then push 8'hFF -> full=1, level=8, overrun=1, rx_irq=1; eight pops return 00..07 in order, FF never appears.
REQ-036 Hold rx_done high 5 cycles with 8'hA5 -> level=1 only; frame with rx_err=1 and 8'h5A -> level unchanged, frame_err=1; clr_flags -> frame_err=0.
REQ-037 Fill to 8, then same-cycle push 8'h42 and pop -> overrun stays 0, level=8, popped byte is the oldest; continue through 20 push/pop pairs -> correct order across pointer wrap.
REQ-038 Level 3 -> rx_irq=0; push 4th -> rx_irq=1; pop on empty -> no rd_valid, rd_data unchanged.
REQ-039 Level 5, then arst_n low mid-stream -> all outputs at REQ-031 values; separately rst with simultaneous push -> level=0 next cycle.
